pma_attr_responder: RTL and testbench

- Sequential responder for Physical Memory Attribute (PMA) lookups issued by initiators such as fetch, LSU and PTW.
- Accepts one physical address per valid/ready handshake and scans the CVA6Cfg rule tables at RulesPerCycle rules per cycle.
- Returns the non-idempotent, executable and cacheable attributes through a valid/ready response.
- Results are bit-exact with config_pkg::is_inside_nonidempotent_regions, is_inside_execute_regions and is_inside_cacheable_regions for the same Cfg and address.

---
 rtl/pma_attr_responder_pkg.sv | 51 +++++
 rtl/pma_rule_slice.sv | 30 +++
 rtl/pma_attr_responder.sv | 161 ++++++++++++++++
 tb/tb_pma_attr_responder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pma_attr_responder_pkg.sv
// Shared configuration type, attribute struct, FSM states and the range check
// used by the PMA attribute responder.
package pma_attr_responder_pkg;

    localparam int unsigned NrMaxRules          = 16;
    localparam int unsigned RuleIdxW            = $clog2(NrMaxRules);
    localparam int unsigned PmaMaxRulesPerCycle = 16;
    localparam int unsigned IdxW                = 8;

    typedef struct packed {
        int unsigned                 NrNonIdempotentRules;
        logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
        logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
        int unsigned                 NrExecuteRegionRules;
        logic [NrMaxRules-1:0][63:0] ExecuteRegionAddrBase;
        logic [NrMaxRules-1:0][63:0] ExecuteRegionLength;
        int unsigned                 NrCachedRegionRules;
        logic [NrMaxRules-1:0][63:0] CachedRegionAddrBase;
        logic [NrMaxRules-1:0][63:0] CachedRegionLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

    typedef struct packed {
        logic nonidem;
        logic exec;
        logic cache;
    } pma_attr_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_e;

    // The end of a region is computed in 65 bits so base+len == 2^64 does not wrap.
    function automatic logic range_check(input logic [63:0] base,
                                         input logic [63:0] len,
                                         input logic [63:0] address);
        return (address >= base) && ({1'b0, address} < ({1'b0, base} + {1'b0, len}));
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pma_rule_slice.sv
// Combinational evaluation of RulesPerCycle consecutive rules of one PMA table,
// starting at idx_i; hits are ORed together.
module pma_rule_slice
    import pma_attr_responder_pkg::*;
#(
    parameter int unsigned RulesPerCycle = 4,
    parameter int unsigned NrRules       = 0
) (
    input  logic [IdxW-1:0]             idx_i,
    input  logic [63:0]                 addr_i,
    input  logic [NrMaxRules-1:0][63:0] base_i,
    input  logic [NrMaxRules-1:0][63:0] len_i,
    output logic                        hit_o
);

    logic [IdxW-1:0] k;

    // Rules past the end of the table are masked so they can never hit.
    always_comb begin
        hit_o = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < RulesPerCycle; i++) begin
            k = idx_i + IdxW'(i);
            if (32'(k) < NrRules) begin
                hit_o = hit_o | range_check(base_i[k[RuleIdxW-1:0]], len_i[k[RuleIdxW-1:0]], addr_i);
            end
        end
    end

endmodule

// File: rtl/pma_attr_responder.sv
// Sequential PMA attribute responder: scans the three rule tables RulesPerCycle rules
// per cycle. Optional last-hit entry enabled by defining PMA_ATTR_LAST_HIT_EN.
module pma_attr_responder
    import pma_attr_responder_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg       = cva6_cfg_empty,
    parameter int unsigned RulesPerCycle = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_nonidem_o,
    output logic        rsp_exec_o,
    output logic        rsp_cache_o,
    output logic        busy_o
);

    localparam int unsigned MaxRules = max3(CVA6Cfg.NrNonIdempotentRules,
                                            CVA6Cfg.NrExecuteRegionRules,
                                            CVA6Cfg.NrCachedRegionRules);
    localparam int unsigned NScan    = (MaxRules + RulesPerCycle - 1) / RulesPerCycle;
    localparam logic [IdxW-1:0] Step    = IdxW'(RulesPerCycle);
    localparam logic [IdxW-1:0] LastIdx = (NScan == 0) ? '0 : IdxW'((NScan - 1) * RulesPerCycle);

    state_e          state_q, state_d;
    logic [63:0]     addr_q, addr_d;
    logic [IdxW-1:0] idx_q, idx_d;
    pma_attr_t       attr_q, attr_d;
    pma_attr_t       scan_hit;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;
`ifdef PMA_ATTR_LAST_HIT_EN
    logic            hit_valid_q, hit_valid_d;
    logic [63:0]     hit_addr_q, hit_addr_d;
    pma_attr_t       hit_attr_q, hit_attr_d;
`endif

    pma_rule_slice #(.RulesPerCycle(RulesPerCycle), .NrRules(CVA6Cfg.NrNonIdempotentRules)) u_slice_nonidem (
        .idx_i (idx_q),
        .addr_i(addr_q),
        .base_i(CVA6Cfg.NonIdempotentAddrBase),
        .len_i (CVA6Cfg.NonIdempotentLength),
        .hit_o (scan_hit.nonidem)
    );

    pma_rule_slice #(.RulesPerCycle(RulesPerCycle), .NrRules(CVA6Cfg.NrExecuteRegionRules)) u_slice_exec (
        .idx_i (idx_q),
        .addr_i(addr_q),
        .base_i(CVA6Cfg.ExecuteRegionAddrBase),
        .len_i (CVA6Cfg.ExecuteRegionLength),
        .hit_o (scan_hit.exec)
    );

    pma_rule_slice #(.RulesPerCycle(RulesPerCycle), .NrRules(CVA6Cfg.NrCachedRegionRules)) u_slice_cache (
        .idx_i (idx_q),
        .addr_i(addr_q),
        .base_i(CVA6Cfg.CachedRegionAddrBase),
        .len_i (CVA6Cfg.CachedRegionLength),
        .hit_o (scan_hit.cache)
    );

    // Flush wins over everything; outputs are derived from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        attr_d  = attr_q;
`ifdef PMA_ATTR_LAST_HIT_EN
        hit_valid_d = hit_valid_q;
        hit_addr_d  = hit_addr_q;
        hit_attr_d  = hit_attr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_q && !flush_i) begin
                    addr_d  = req_addr_i;
                    idx_d   = '0;
                    attr_d  = '0;
                    state_d = (NScan > 0) ? SCAN : RESP;
`ifdef PMA_ATTR_LAST_HIT_EN
                    if (hit_valid_q && (req_addr_i == hit_addr_q)) begin
                        attr_d  = hit_attr_q;
                        state_d = RESP;
                    end
`endif
                end
            end
            SCAN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    attr_d = attr_q | scan_hit;
                    idx_d  = idx_q + Step;
                    if (idx_q == LastIdx) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (rsp_ready_i) begin
                    state_d = IDLE;
`ifdef PMA_ATTR_LAST_HIT_EN
                    hit_valid_d = 1'b1;
                    hit_addr_d  = addr_q;
                    hit_attr_d  = attr_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            idx_q       <= '0;
            attr_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PMA_ATTR_LAST_HIT_EN
            hit_valid_q <= 1'b0;
            hit_addr_q  <= '0;
            hit_attr_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            attr_q      <= attr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef PMA_ATTR_LAST_HIT_EN
            hit_valid_q <= hit_valid_d;
            hit_addr_q  <= hit_addr_d;
            hit_attr_q  <= hit_attr_d;
`endif
        end
    end

    assign req_ready_o   = req_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_nonidem_o = attr_q.nonidem;
    assign rsp_exec_o    = attr_q.exec;
    assign rsp_cache_o   = attr_q.cache;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_pma_attr_responder.sv
// Directed bench for pma_attr_responder: three instances (single-rule, nine execute
// rules, empty config) with hand-computed attributes and latencies.
module tb_pma_attr_responder;
    import pma_attr_responder_pkg::*;

    function automatic cva6_cfg_t make_cfg_a();
        cva6_cfg_t c;
        c = '0;
        c.NrCachedRegionRules      = 1;
        c.CachedRegionAddrBase[0]  = 64'h0000_0000_8000_0000;
        c.CachedRegionLength[0]    = 64'h0000_0000_4000_0000;
        c.NrNonIdempotentRules     = 1;
        c.NonIdempotentAddrBase[0] = 64'hFFFF_FFFF_FFFF_F000;
        c.NonIdempotentLength[0]   = 64'h0000_0000_0000_1000;
        return c;
    endfunction

    function automatic cva6_cfg_t make_cfg_b();
        cva6_cfg_t c;
        c = '0;
        c.NrExecuteRegionRules = 9;
        for (int i = 0; i < 8; i++) begin
            c.ExecuteRegionAddrBase[i] = 64'h1000_0000 + 64'(i) * 64'h1000;
            c.ExecuteRegionLength[i]   = 64'h1000;
        end
        c.ExecuteRegionAddrBase[8] = 64'h2000_0000;
        c.ExecuteRegionLength[8]   = 64'h100;
        return c;
    endfunction

    localparam cva6_cfg_t CfgA = make_cfg_a();
    localparam cva6_cfg_t CfgB = make_cfg_b();

    logic        clk;
    logic        rst_n;
    logic [2:0]  flush, req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0]  nonidem, exec, cache, busy;
    logic [63:0] req_addr [3];

    int total;
    int bad;

    pma_attr_responder #(.CVA6Cfg(CfgA), .RulesPerCycle(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_nonidem_o(nonidem[0]), .rsp_exec_o(exec[0]), .rsp_cache_o(cache[0]), .busy_o(busy[0])
    );

    pma_attr_responder #(.CVA6Cfg(CfgB), .RulesPerCycle(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_nonidem_o(nonidem[1]), .rsp_exec_o(exec[1]), .rsp_cache_o(cache[1]), .busy_o(busy[1])
    );

    pma_attr_responder #(.CVA6Cfg(cva6_cfg_empty), .RulesPerCycle(4)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[2]),
        .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_addr_i(req_addr[2]),
        .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]),
        .rsp_nonidem_o(nonidem[2]), .rsp_exec_o(exec[2]), .rsp_cache_o(cache[2]), .busy_o(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Handshake a request, then count cycles from the handshake edge to rsp_valid.
    task automatic issue(input int d, input logic [63:0] a, input logic ack,
                         output int lat, output logic [2:0] at);
        req_addr[d]  = a;
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        at = {nonidem[d], exec[d], cache[d]};
        if (ack) begin
            rsp_ready[d] = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({req_ready[d], rsp_valid[d], nonidem[d], exec[d], cache[d], busy[d]} !== 6'b100000) begin
                bad++;
                $display("[TB] FAIL reset_state dut=%0d got=%b exp=%b", d,
                         {req_ready[d], rsp_valid[d], nonidem[d], exec[d], cache[d], busy[d]}, 6'b100000);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_rule();
        logic [63:0] addrs [6];
        logic [2:0]  exp   [6];
        int          lat;
        logic [2:0]  at;
        addrs = '{64'h8000_0000, 64'hC000_0000, 64'hBFFF_FFFF, 64'h7FFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        exp   = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b100, 3'b000};
        for (int i = 0; i < 6; i++) begin
            issue(0, addrs[i], 1'b1, lat, at);
            total++;
            if (at !== exp[i]) begin
                bad++;
                $display("[TB] FAIL single_attr addr=%h got=%b exp=%b", addrs[i], at, exp[i]);
            end
            total++;
            if (lat !== 2) begin
                bad++;
                $display("[TB] FAIL single_latency addr=%h got=%0d exp=2", addrs[i], lat);
            end
        end
    endtask

    task automatic test_multi_scan();
        logic [63:0] addrs [3];
        logic [2:0]  exp   [3];
        int          lat;
        logic [2:0]  at;
        addrs = '{64'h2000_0080, 64'h1000_3010, 64'h3000_0000};
        exp   = '{3'b010, 3'b010, 3'b000};
        for (int i = 0; i < 3; i++) begin
            issue(1, addrs[i], 1'b1, lat, at);
            total++;
            if (at !== exp[i]) begin
                bad++;
                $display("[TB] FAIL multi_attr addr=%h got=%b exp=%b", addrs[i], at, exp[i]);
            end
            total++;
            if (lat !== 4) begin
                bad++;
                $display("[TB] FAIL multi_latency addr=%h got=%0d exp=4", addrs[i], lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int         lat;
        logic [2:0] at;
        issue(1, 64'h2000_00FF, 1'b0, lat, at);
        total++;
        if (lat !== 4) begin
            bad++;
            $display("[TB] FAIL bp_latency got=%0d exp=4", lat);
        end
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({rsp_valid[1], req_ready[1], nonidem[1], exec[1], cache[1]} !== 5'b10010) begin
                bad++;
                $display("[TB] FAIL bp_hold cycle=%0d got=%b exp=%b", c,
                         {rsp_valid[1], req_ready[1], nonidem[1], exec[1], cache[1]}, 5'b10010);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b0;
        total++;
        if ({rsp_valid[1], req_ready[1], busy[1]} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL bp_release got=%b exp=010", {rsp_valid[1], req_ready[1], busy[1]});
        end
    endtask

    task automatic test_flush();
        int seen;
        req_addr[1]  = 64'h2000_0080;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        flush[1] = 1'b1;
        @(posedge clk);
        #1;
        flush[1] = 1'b0;
        total++;
        if ({rsp_valid[1], req_ready[1], busy[1]} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL flush_scan got=%b exp=010", {rsp_valid[1], req_ready[1], busy[1]});
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid[1]) seen++;
            @(posedge clk);
            #1;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("[TB] FAIL flush_no_rsp got=%0d exp=0", seen);
        end
        // Flush in IDLE must suppress acceptance.
        req_addr[2]  = 64'h1234;
        req_valid[2] = 1'b1;
        flush[2]     = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        flush[2]     = 1'b0;
        total++;
        if ({rsp_valid[2], busy[2]} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL flush_idle got=%b exp=00", {rsp_valid[2], busy[2]});
        end
    endtask

    task automatic test_empty_cfg();
        logic [63:0] addrs [3];
        int          lat;
        logic [2:0]  at;
        addrs = '{64'h8000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            issue(2, addrs[i], 1'b1, lat, at);
            total++;
            if ({lat[3:0], at} !== {4'd1, 3'b000}) begin
                bad++;
                $display("[TB] FAIL empty_cfg addr=%h lat=%0d attr=%b exp lat=1 attr=000", addrs[i], lat, at);
            end
        end
    endtask

    task automatic test_last_hit();
        int         lat;
        int         exp_lat;
        logic [2:0] at;
`ifdef PMA_ATTR_LAST_HIT_EN
        exp_lat = 1;
`else
        exp_lat = 2;
`endif
        issue(0, 64'h8000_0010, 1'b1, lat, at);
        total++;
        if (lat !== 2 || at !== 3'b001) begin
            bad++;
            $display("[TB] FAIL repeat_first lat=%0d attr=%b exp lat=2 attr=001", lat, at);
        end
        issue(0, 64'h8000_0010, 1'b1, lat, at);
        total++;
        if (lat !== exp_lat || at !== 3'b001) begin
            bad++;
            $display("[TB] FAIL repeat_second lat=%0d attr=%b exp lat=%0d attr=001", lat, at, exp_lat);
        end
        apply_reset();
        issue(0, 64'h8000_0010, 1'b1, lat, at);
        total++;
        if (lat !== 2 || at !== 3'b001) begin
            bad++;
            $display("[TB] FAIL repeat_after_reset lat=%0d attr=%b exp lat=2 attr=001", lat, at);
        end
    endtask

    task automatic test_reset_midscan();
        req_addr[1]  = 64'h2000_0080;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rsp_valid[1], req_ready[1], busy[1], exec[1]} !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL reset_midscan got=%b exp=0100", {rsp_valid[1], req_ready[1], busy[1], exec[1]});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if ({rsp_valid[1], busy[1]} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_midscan_idle got=%b exp=00", {rsp_valid[1], busy[1]});
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        flush     = '0;
        req_valid = '0;
        rsp_ready = '0;
        for (int d = 0; d < 3; d++) req_addr[d] = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_rule();
        test_multi_scan();
        test_backpressure();
        test_flush();
        test_empty_cfg();
        test_last_hit();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
